// File: rtl/bcd_conv_pkg.sv
// Shared definitions for the binary-to-BCD converter: digit width, default
// digit count and the converter state encoding.
package bcd_conv_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam int HEX_DIGITS  = 5;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

endpackage : bcd_conv_pkg

// File: rtl/bcd_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so the
// following left shift carries correctly into the next decade.
module bcd_adj
    import bcd_conv_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    output logic [BCD_DIGIT_W-1:0] digit_o
);

    always_comb begin
        if (digit_i >= BCD_DIGIT_W'(5)) begin
            digit_o = digit_i + BCD_DIGIT_W'(3);
        end else begin
            digit_o = digit_i;
        end
    end

endmodule : bcd_adj

// File: rtl/bcd_conv.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock) with
// sign handling and leading-zero blanking flags for 7-segment displays.
module bcd_conv
    import bcd_conv_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = HEX_DIGITS
) (
    input  logic                          iCLK,
    input  logic                          iRST,
    input  logic                          iSTART,
    input  logic                          iSIGNED,
    input  logic [WIDTH-1:0]              iBIN,
    output logic                          oBUSY,
    output logic                          oDONE,
    output logic                          oNEG,
    output logic [BCD_DIGIT_W*DIGITS-1:0] oBCD,
    output logic [DIGITS-1:0]             oBLANK
);

    localparam int SCR_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(WIDTH - 1);
    localparam logic [DIGITS-1:0] RST_BLANK = {{(DIGITS-1){1'b1}}, 1'b0};

    state_e               state_q,    state_d;
    logic [WIDTH-1:0]     shreg_q,    shreg_d;
    logic [SCR_W-1:0]     scratch_q,  scratch_d;
    logic [CNT_W-1:0]     cnt_q,      cnt_d;
    logic                 neg_pend_q, neg_pend_d;
    logic                 busy_q,     busy_d;
    logic                 done_q,     done_d;
    logic                 neg_q,      neg_d;
    logic [SCR_W-1:0]     bcd_q,      bcd_d;
    logic [DIGITS-1:0]    blank_q,    blank_d;

    logic [SCR_W-1:0]     adj_scratch;
    logic [SCR_W-1:0]     shifted_scratch;
    logic [DIGITS-1:0]    final_blank;
    logic                 higher_zero;
    logic                 start_neg;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_adj u_adj (
            .digit_i (scratch_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_o (adj_scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    assign shifted_scratch = {adj_scratch[SCR_W-2:0], shreg_q[WIDTH-1]};
    assign start_neg       = iSIGNED & iBIN[WIDTH-1];

    // A digit is blanked only while it and every digit above it are zero.
    always_comb begin
        higher_zero = 1'b1;
        final_blank = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            higher_zero    = higher_zero &
                             (shifted_scratch[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
            final_blank[i] = higher_zero;
        end
    end

    always_comb begin
        // NOTE: every next-state value defaults to its register so no path
        // through the case statement can leave a signal unassigned (latch).
        state_d    = state_q;
        shreg_d    = shreg_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        neg_pend_d = neg_pend_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        neg_d      = neg_q;
        bcd_d      = bcd_q;
        blank_d    = blank_q;

        case (state_q)
            ST_IDLE: begin
                if (iSTART) begin
                    state_d    = ST_SHIFT;
                    busy_d     = 1'b1;
                    neg_pend_d = start_neg;
                    // 0x8000 negates to itself, which read unsigned is 32768.
                    shreg_d    = start_neg ? (~iBIN) + WIDTH'(1) : iBIN;
                    scratch_d  = '0;
                    cnt_d      = '0;
                end
            end
            ST_SHIFT: begin
                scratch_d = shifted_scratch;
                shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    bcd_d   = shifted_scratch;
                    neg_d   = neg_pend_q;
                    blank_d = final_blank;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            neg_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            neg_q      <= 1'b0;
            bcd_q      <= '0;
            blank_q    <= RST_BLANK;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            neg_pend_q <= neg_pend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            neg_q      <= neg_d;
            bcd_q      <= bcd_d;
            blank_q    <= blank_d;
        end
    end

    assign oBUSY  = busy_q;
    assign oDONE  = done_q;
    assign oNEG   = neg_q;
    assign oBCD   = bcd_q;
    assign oBLANK = blank_q;

endmodule : bcd_conv

// File: tb/tb_bcd_conv.sv
// Self-checking bench for bcd_conv: directed vectors, back-to-back, ignored
// starts, mid-conversion reset and randomized conversions vs. a decimal model.
module tb_bcd_conv;

    localparam int WIDTH  = 16;
    localparam int DIGITS = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sgn;
    logic [15:0] bin;
    logic        busy, done, neg;
    logic [19:0] bcd;
    logic [4:0]  blank;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [19:0] r_bcd;
    logic        r_neg;
    logic [4:0]  r_blank;
    logic        r_busy_at_done;
    int          r_lat;
    int          r_busy;

    bcd_conv #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .iCLK    (clk),
        .iRST    (rst),
        .iSTART  (start),
        .iSIGNED (sgn),
        .iBIN    (bin),
        .oBUSY   (busy),
        .oDONE   (done),
        .oNEG    (neg),
        .oBCD    (bcd),
        .oBLANK  (blank)
    );

    always #5 clk = ~clk;

    // Decimal reference: magnitude by integer arithmetic, digits by div/mod,
    // digit i (i>0) blank exactly when the magnitude is below 10^i.
    function automatic void model(input logic [15:0] b, input logic s,
                                  output logic [19:0] m_bcd, output logic m_neg,
                                  output logic [4:0] m_blank);
        int mag;
        int p;
        m_neg   = s && b[15];
        mag     = m_neg ? 65536 - int'(b) : int'(b);
        m_bcd   = '0;
        m_blank = '0;
        p       = 1;
        for (int i = 0; i < 5; i++) begin
            m_bcd[i*4 +: 4] = 4'((mag / p) % 10);
            if (i > 0 && mag < p) m_blank[i] = 1'b1;
            p = p * 10;
        end
    endfunction

    // Start one conversion from IDLE and wait (bounded) for oDONE.
    task automatic run_conv(input logic [15:0] b, input logic s);
        @(negedge clk);
        bin   = b;
        sgn   = s;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        r_lat  = 0;
        r_busy = 0;
        while (!done && r_lat < 40) begin
            if (busy) r_busy++;
            r_lat++;
            @(negedge clk);
        end
        r_bcd          = bcd;
        r_neg          = neg;
        r_blank        = blank;
        r_busy_at_done = busy;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        sgn   = 1'b0;
        bin   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else pass_cnt++;
        total_cnt++; if (neg !== 1'b0) $display("FAIL reset_neg got=%b exp=0", neg); else pass_cnt++;
        total_cnt++; if (bcd !== 20'h0) $display("FAIL reset_bcd got=%h exp=00000", bcd); else pass_cnt++;
        total_cnt++; if (blank !== 5'b11110) $display("FAIL reset_blank got=%b exp=11110", blank); else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [15:0] v_bin   [6] = '{16'd42, 16'hFFFF, 16'hFFFF, 16'h8000, 16'd0, 16'd0};
        logic        v_sgn   [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [19:0] v_bcd   [6] = '{20'h00042, 20'h65535, 20'h00001, 20'h32768, 20'h00000, 20'h00000};
        logic        v_neg   [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [4:0]  v_blank [6] = '{5'b11100, 5'b00000, 5'b11110, 5'b00000, 5'b11110, 5'b11110};
        for (int i = 0; i < 6; i++) begin
            run_conv(v_bin[i], v_sgn[i]);
            total_cnt++; if (r_lat !== 16) $display("FAIL dir%0d_latency got=%0d exp=16", i, r_lat); else pass_cnt++;
            total_cnt++; if (r_busy !== 16) $display("FAIL dir%0d_busy_width got=%0d exp=16", i, r_busy); else pass_cnt++;
            total_cnt++; if (r_bcd !== v_bcd[i]) $display("FAIL dir%0d_bcd got=%h exp=%h", i, r_bcd, v_bcd[i]); else pass_cnt++;
            total_cnt++; if (r_neg !== v_neg[i]) $display("FAIL dir%0d_neg got=%b exp=%b", i, r_neg, v_neg[i]); else pass_cnt++;
            total_cnt++; if (r_blank !== v_blank[i]) $display("FAIL dir%0d_blank got=%b exp=%b", i, r_blank, v_blank[i]); else pass_cnt++;
        end
        @(negedge clk);
        total_cnt++; if (done !== 1'b0) $display("FAIL done_pulse_width got=%b exp=0", done); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int lat;
        int gap;
        @(negedge clk);
        bin   = 16'd9999;
        sgn   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bin = 16'd10000;
        lat = 0;
        while (!done && lat < 40) begin
            lat++;
            @(negedge clk);
        end
        total_cnt++; if (lat !== 16) $display("FAIL b2b_first_latency got=%0d exp=16", lat); else pass_cnt++;
        total_cnt++; if (bcd !== 20'h09999) $display("FAIL b2b_first_bcd got=%h exp=09999", bcd); else pass_cnt++;
        gap = 1;
        @(negedge clk);
        while (!done && gap < 40) begin
            if (gap == 8) begin
                total_cnt++; if (bcd !== 20'h09999) $display("FAIL b2b_hold_bcd got=%h exp=09999", bcd); else pass_cnt++;
                total_cnt++; if (busy !== 1'b1) $display("FAIL b2b_busy got=%b exp=1", busy); else pass_cnt++;
            end
            gap++;
            @(negedge clk);
        end
        start = 1'b0;
        total_cnt++; if (gap !== 17) $display("FAIL b2b_gap got=%0d exp=17", gap); else pass_cnt++;
        total_cnt++; if (bcd !== 20'h10000) $display("FAIL b2b_second_bcd got=%h exp=10000", bcd); else pass_cnt++;
        total_cnt++; if (blank !== 5'b00000) $display("FAIL b2b_second_blank got=%b exp=00000", blank); else pass_cnt++;
        repeat (3) @(negedge clk);
        total_cnt++; if (busy !== 1'b0) $display("FAIL b2b_stop_busy got=%b exp=0", busy); else pass_cnt++;
    endtask

    task automatic test_ignore_start();
        int lat;
        int extra;
        @(negedge clk);
        bin   = 16'd1234;
        sgn   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        while (!done && lat < 40) begin
            if (lat == 5) begin
                start = 1'b1;
                bin   = 16'd777;
                sgn   = 1'b1;
            end else begin
                start = 1'b0;
            end
            lat++;
            @(negedge clk);
        end
        start = 1'b0;
        total_cnt++; if (lat !== 16) $display("FAIL ign_latency got=%0d exp=16", lat); else pass_cnt++;
        total_cnt++; if (bcd !== 20'h01234) $display("FAIL ign_bcd got=%h exp=01234", bcd); else pass_cnt++;
        total_cnt++; if (neg !== 1'b0) $display("FAIL ign_neg got=%b exp=0", neg); else pass_cnt++;
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy || done) extra++;
        end
        total_cnt++; if (extra !== 0) $display("FAIL ign_no_queue got=%0d exp=0", extra); else pass_cnt++;
    endtask

    task automatic test_abort();
        int dones;
        logic [19:0] m_bcd;
        logic        m_neg;
        logic [4:0]  m_blank;
        @(negedge clk);
        bin   = 16'd54321;
        sgn   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        total_cnt++; if (busy !== 1'b1) $display("FAIL abort_busy_before got=%b exp=1", busy); else pass_cnt++;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        total_cnt++; if (busy !== 1'b0) $display("FAIL abort_busy got=%b exp=0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL abort_done got=%b exp=0", done); else pass_cnt++;
        total_cnt++; if (neg !== 1'b0) $display("FAIL abort_neg got=%b exp=0", neg); else pass_cnt++;
        total_cnt++; if (bcd !== 20'h0) $display("FAIL abort_bcd got=%h exp=00000", bcd); else pass_cnt++;
        total_cnt++; if (blank !== 5'b11110) $display("FAIL abort_blank got=%b exp=11110", blank); else pass_cnt++;
        dones = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) dones++;
        end
        total_cnt++; if (dones !== 0) $display("FAIL abort_no_done got=%0d exp=0", dones); else pass_cnt++;
        run_conv(16'hD431, 1'b1);
        model(16'hD431, 1'b1, m_bcd, m_neg, m_blank);
        total_cnt++; if (r_bcd !== m_bcd) $display("FAIL abort_fresh_bcd got=%h exp=%h", r_bcd, m_bcd); else pass_cnt++;
        total_cnt++; if (r_neg !== m_neg) $display("FAIL abort_fresh_neg got=%b exp=%b", r_neg, m_neg); else pass_cnt++;
    endtask

    task automatic test_random();
        logic [15:0] b;
        logic        s;
        logic [19:0] m_bcd;
        logic        m_neg;
        logic [4:0]  m_blank;
        for (int n = 0; n < 60; n++) begin
            b = 16'($urandom_range(0, 65535));
            if (n % 10 == 0) b = 16'($urandom_range(0, 120));
            s = 1'($urandom_range(0, 1));
            model(b, s, m_bcd, m_neg, m_blank);
            run_conv(b, s);
            total_cnt++; if (r_lat !== 16) $display("FAIL rnd%0d_latency got=%0d exp=16", n, r_lat); else pass_cnt++;
            total_cnt++; if (r_busy !== 16 || r_busy_at_done !== 1'b0)
                $display("FAIL rnd%0d_busy got=%0d/%b exp=16/0", n, r_busy, r_busy_at_done); else pass_cnt++;
            total_cnt++; if (r_bcd !== m_bcd)
                $display("FAIL rnd%0d_bcd bin=%h s=%b got=%h exp=%h", n, b, s, r_bcd, m_bcd); else pass_cnt++;
            total_cnt++; if (r_neg !== m_neg) $display("FAIL rnd%0d_neg got=%b exp=%b", n, r_neg, m_neg); else pass_cnt++;
            total_cnt++; if (r_blank !== m_blank)
                $display("FAIL rnd%0d_blank bin=%h got=%b exp=%b", n, b, r_blank, m_blank); else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_ignore_start();
        test_abort();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_bcd_conv
